mega_ram_arb: RTL and testbench
===============================

MEGA_RAM_ARB -- requirements
Module: mega_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_BUS_WIDTH, default 12, the RAM address width in lines.
REQ-002 SHALL have parameter DATA_BUS_WIDTH, default 8, the data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, the count of consecutive denied ext cycles before a forced ext grant; legal range 1..15.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cpu_rd  in  1  CPU data-space read strobe, one cycle per access.
REQ-007 cpu_wr  in  1  CPU data-space write strobe, one cycle per access.
REQ-008 cpu_a  in  ADDR_BUS_WIDTH  CPU address.
REQ-009 cpu_d_in  in  DATA_BUS_WIDTH  CPU write data.
REQ-010 cpu_d_out  out  DATA_BUS_WIDTH  CPU read data, equal to ram_d_out.
REQ-011 cpu_stall  out  1  CPU access not taken this cycle; CPU holds strobes, address and data.
REQ-012 ext_req  in  1  external (loader/debug) access request, held until ext_ack.
REQ-013 ext_we  in  1  external write (1) or read (0), valid with ext_req.
REQ-014 ext_a  in  ADDR_BUS_WIDTH  external address.
REQ-015 ext_d_in  in  DATA_BUS_WIDTH  external write data.
REQ-016 ext_ack  out  1  external access taken this cycle.
REQ-017 ext_rvalid  out  1  ext_d_out valid, one-cycle pulse.
REQ-018 ext_d_out  out  DATA_BUS_WIDTH  external read data.
REQ-019 ram_we  out  1  RAM write enable.
REQ-020 ram_a  out  ADDR_BUS_WIDTH  RAM address.
REQ-021 ram_d_in  out  DATA_BUS_WIDTH  RAM write data.
REQ-022 ram_d_out  in  DATA_BUS_WIDTH  RAM registered read data, valid one cycle after ram_a presented.

Function
REQ-023 cpu_acc = cpu_rd | cpu_wr; force = (wait_cnt >= STARVE_LIMIT); ext_sel = ext_req & !rst & (!cpu_acc | force), all combinational.
REQ-024 ext_ack SHALL equal ext_sel; cpu_stall SHALL equal cpu_acc & ext_sel.
REQ-025 When ext_sel: ram_a=ext_a, ram_d_in=ext_d_in, ram_we=ext_we.
REQ-026 Otherwise: ram_a=cpu_a, ram_d_in=cpu_d_in, ram_we=cpu_wr & !rst.
REQ-027 cpu_rd and cpu_wr both high SHALL be treated as a write to cpu_a; ram_d_out on next cycle is the pre-write value.
REQ-028 wait_cnt (4 bits) SHALL increment, saturating at 15, on each cycle with ext_req & !ext_sel; clear on ext_sel or !ext_req.
REQ-029 rd_pend register SHALL be set on a cycle with ext_sel & !ext_we, cleared otherwise.
REQ-030 ext_rvalid SHALL equal rd_pend; ext_d_out SHALL equal ram_d_out while rd_pend, else hold last captured value (register captured on rd_pend cycle, forwarded combinationally that cycle).
REQ-031 Back-to-back ext accesses SHALL be legal: ext_req held high after ack yields one access per cycle while CPU idle; rvalid pulses overlap new acks with one-cycle offset.
REQ-032 Forced grant SHALL stall the CPU exactly one cycle; the held CPU access completes the following cycle unless force recurs (impossible with wait_cnt cleared, so CPU stall max 1 cycle per STARVE_LIMIT+1).
REQ-033 ext_req dropped without ack SHALL clear wait_cnt; no access performed.

Reset
REQ-034 While rst: ext_ack=0, cpu_stall=0, ext_rvalid=0, ram_we=0, ram_a=cpu_a.
REQ-035 On any rst cycle: wait_cnt=0, rd_pend=0, ext_d_out register=0; reset mid-read SHALL suppress the pending ext_rvalid.

Verification
REQ-036 CPU idle, ext write a=0x010 d=0xA5, then ext read a=0x010 -> ack each cycle, rvalid one cycle after read ack, ext_d_out=0xA5.
REQ-037 cpu_rd high continuously, ext_req held, STARVE_LIMIT=4 -> ext_ack low 4 cycles, high 5th cycle with cpu_stall=1 that cycle only, wait_cnt back to 0.
REQ-038 cpu_wr a=0x020 d=0x3C same cycle as ext_req, wait_cnt=0 -> ram_we=1, ram_a=0x020, ext_ack=0, cpu_stall=0.
REQ-039 ext read ack then rst asserted next cycle -> ext_rvalid=0, ext_d_out=0, ram_we=0.
REQ-040 ext_req held 3 cycles denied then dropped, raised again -> wait_cnt restarts from 0; grant forced only after 4 new denials.
REQ-041 ext streaming reads 0x000..0x003 with CPU idle -> 4 consecutive acks, 4 consecutive rvalid pulses, data in address order.

Source files
------------

// File: rtl/mega_ram_arb_if.sv
// Bundles the CPU, external and RAM-side signals of the mega RAM arbiter.
// slave: the arbiter's view. master: the view of the surrounding CPU/loader/RAM.
// Carries no state of its own.
interface mega_ram_arb_if #(
  parameter int ADDR_BUS_WIDTH = 12,
  parameter int DATA_BUS_WIDTH = 8
);
  // CPU data-space port
  logic                      cpu_rd;
  logic                      cpu_wr;
  logic [ADDR_BUS_WIDTH-1:0] cpu_a;
  logic [DATA_BUS_WIDTH-1:0] cpu_d_in;
  logic [DATA_BUS_WIDTH-1:0] cpu_d_out;
  logic                      cpu_stall;
  // external loader/debug port
  logic                      ext_req;
  logic                      ext_we;
  logic [ADDR_BUS_WIDTH-1:0] ext_a;
  logic [DATA_BUS_WIDTH-1:0] ext_d_in;
  logic                      ext_ack;
  logic                      ext_rvalid;
  logic [DATA_BUS_WIDTH-1:0] ext_d_out;
  // single-port RAM with registered read data
  logic                      ram_we;
  logic [ADDR_BUS_WIDTH-1:0] ram_a;
  logic [DATA_BUS_WIDTH-1:0] ram_d_in;
  logic [DATA_BUS_WIDTH-1:0] ram_d_out;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_a, cpu_d_in,
    input  ext_req, ext_we, ext_a, ext_d_in,
    input  ram_d_out,
    output cpu_d_out, cpu_stall,
    output ext_ack, ext_rvalid, ext_d_out,
    output ram_we, ram_a, ram_d_in
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_a, cpu_d_in,
    output ext_req, ext_we, ext_a, ext_d_in,
    output ram_d_out,
    input  cpu_d_out, cpu_stall,
    input  ext_ack, ext_rvalid, ext_d_out,
    input  ram_we, ram_a, ram_d_in
  );
endinterface

// File: rtl/mega_ram_arb.sv
// Shares one single-port RAM between the CPU (priority) and an external loader/debug port.
// Latency: grant is combinational; ext read data returns one cycle after ext_ack (ext_rvalid).
// Backpressure: CPU stalls only on a starvation-forced ext grant (max 1 cycle); ext waits for ext_ack.
module mega_ram_arb #(
  parameter int ADDR_BUS_WIDTH = 12,
  parameter int DATA_BUS_WIDTH = 8,
  // consecutive denied ext cycles before the ext port is forced in; 1..15
  parameter int STARVE_LIMIT   = 4
) (
  input logic           clk,
  input logic           rst,
  mega_ram_arb_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                      cpu_acc;
  logic                      force_grant;
  logic                      ext_sel;
  logic [3:0]                wait_cnt;
  logic                      rd_pend;
  logic                      rd_vld;
  logic [DATA_BUS_WIDTH-1:0] ext_rd_q;

  // Arbitration: CPU wins unless idle or the ext port has starved long enough.
  always_comb begin
    cpu_acc     = bus.cpu_rd | bus.cpu_wr;
    force_grant = (wait_cnt >= LIMIT);
    ext_sel     = bus.ext_req & ~rst & (~cpu_acc | force_grant);
  end

  // RAM port mux and handshake outputs; a simultaneous CPU rd+wr is just a write.
  always_comb begin
    bus.ext_ack   = ext_sel;
    bus.cpu_stall = cpu_acc & ext_sel;
    bus.cpu_d_out = bus.ram_d_out;
    if (ext_sel) begin
      bus.ram_a    = bus.ext_a;
      bus.ram_d_in = bus.ext_d_in;
      bus.ram_we   = bus.ext_we;
    end else begin
      bus.ram_a    = bus.cpu_a;
      bus.ram_d_in = bus.cpu_d_in;
      bus.ram_we   = bus.cpu_wr & ~rst;
    end
  end

  // Starvation counter: counts denied ext cycles, cleared by a grant or a dropped request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (bus.ext_req & ~ext_sel) begin
      if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Marks the cycle in which RAM read data for an ext read is on ram_d_out.
  always_ff @(posedge clk) begin
    if (rst) rd_pend <= 1'b0;
    else     rd_pend <= ext_sel & ~bus.ext_we;
  end

  // Holds the last ext read data so ext_d_out stays stable between reads.
  always_ff @(posedge clk) begin
    if (rst)         ext_rd_q <= '0;
    else if (rd_vld) ext_rd_q <= bus.ram_d_out;
  end

  // Ext read return: live RAM data on the valid cycle, held copy otherwise; reset kills an in-flight read.
  always_comb begin
    rd_vld         = rd_pend & ~rst;
    bus.ext_rvalid = rd_vld;
    if (rst)         bus.ext_d_out = '0;
    else if (rd_vld) bus.ext_d_out = bus.ram_d_out;
    else             bus.ext_d_out = ext_rd_q;
  end

endmodule

// File: tb/tb_mega_ram_arb.sv
// Bench for mega_ram_arb: RAM model, directed stimulus, queue-based scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A monitor pops expected read data whenever ext_rvalid or an accepted CPU read returns.
module tb_mega_ram_arb;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] q_ext[$];
  logic [7:0] q_cpu[$];
  logic [7:0] mem [0:4095];
  logic       cpu_chk = 1'b0;

  always #5 clk = ~clk;

  mega_ram_arb_if #(.ADDR_BUS_WIDTH(12), .DATA_BUS_WIDTH(8)) bus();

  mega_ram_arb #(.ADDR_BUS_WIDTH(12), .DATA_BUS_WIDTH(8), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered-read RAM: read returns the pre-write contents on a same-cycle write.
  initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d_in;
    bus.ram_d_out <= mem[bus.ram_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic rd, input logic wr, input logic [11:0] a, input logic [7:0] d);
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_a = a; bus.cpu_d_in = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [11:0] a, input logic [7:0] d);
    bus.ext_req = req; bus.ext_we = we; bus.ext_a = a; bus.ext_d_in = d;
  endtask

  // Monitor: checks returned read data against the scoreboard queues.
  always @(negedge clk) begin
    if (cpu_chk) begin
      if (q_cpu.size() == 0) begin
        total++; bad++;
        $display("FAIL cpu_rdata_unexpected actual=%0h expected=none", bus.cpu_d_out);
      end else begin
        chk("cpu_rdata", 32'(bus.cpu_d_out), 32'(q_cpu.pop_front()));
      end
    end
    cpu_chk = bus.cpu_rd & ~bus.cpu_stall & ~rst;
    if (bus.ext_rvalid) begin
      if (q_ext.size() == 0) begin
        total++; bad++;
        $display("FAIL ext_rvalid_unexpected actual=%0h expected=none", bus.ext_d_out);
      end else begin
        chk("ext_rdata", 32'(bus.ext_d_out), 32'(q_ext.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] v;
    rst = 1'b1;
    set_cpu(1'b0, 1'b1, 12'h055, 8'h99);
    set_ext(1'b1, 1'b1, 12'h0AA, 8'h11);
    repeat (2) @(posedge clk);
    #1;
    // reset state with both requesters active
    smp();
    chk("rst_ack",    32'(bus.ext_ack),    32'd0);
    chk("rst_stall",  32'(bus.cpu_stall),  32'd0);
    chk("rst_rvalid", 32'(bus.ext_rvalid), 32'd0);
    chk("rst_we",     32'(bus.ram_we),     32'd0);
    chk("rst_ram_a",  32'(bus.ram_a),      32'h055);
    chk("rst_dout",   32'(bus.ext_d_out),  32'd0);
    tick();
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    set_ext(1'b0, 1'b0, 12'h000, 8'h00);
    smp(); tick();

    // ext write then ext read with CPU idle
    set_ext(1'b1, 1'b1, 12'h010, 8'hA5);
    smp();
    chk("w_ack", 32'(bus.ext_ack),  32'd1);
    chk("w_we",  32'(bus.ram_we),   32'd1);
    chk("w_a",   32'(bus.ram_a),    32'h010);
    chk("w_din", 32'(bus.ram_d_in), 32'hA5);
    tick();
    set_ext(1'b1, 1'b0, 12'h010, 8'h00);
    q_ext.push_back(8'hA5);
    smp();
    chk("r_ack",    32'(bus.ext_ack),    32'd1);
    chk("r_we",     32'(bus.ram_we),     32'd0);
    chk("r_rv_pre", 32'(bus.ext_rvalid), 32'd0);
    tick();
    set_ext(1'b0, 1'b0, 12'h000, 8'h00);
    smp();
    chk("r_rv_pulse", 32'(bus.ext_rvalid), 32'd1);
    tick();
    smp();
    chk("r_rv_off",  32'(bus.ext_rvalid), 32'd0);
    chk("r_hold",    32'(bus.ext_d_out),  32'hA5);
    tick();

    // preload 0..3 through the CPU, then stream ext reads
    for (int i = 0; i < 4; i++) begin
      v = 8'((i + 1) * 17);
      set_cpu(1'b0, 1'b1, 12'(i), v);
      smp();
      chk("pre_we",  32'(bus.ram_we),   32'd1);
      chk("pre_din", 32'(bus.ram_d_in), 32'(v));
      tick();
    end
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    for (int i = 0; i < 4; i++) begin
      set_ext(1'b1, 1'b0, 12'(i), 8'h00);
      q_ext.push_back(8'((i + 1) * 17));
      smp();
      chk("str_ack", 32'(bus.ext_ack),    32'd1);
      chk("str_rv",  32'(bus.ext_rvalid), 32'(i > 0));
      tick();
    end
    set_ext(1'b0, 1'b0, 12'h000, 8'h00);
    smp();
    chk("str_rv_tail", 32'(bus.ext_rvalid), 32'd1);
    tick();
    smp();
    chk("str_rv_end", 32'(bus.ext_rvalid), 32'd0);
    tick();

    // CPU write wins against a fresh ext request
    set_cpu(1'b0, 1'b1, 12'h020, 8'h3C);
    set_ext(1'b1, 1'b0, 12'h300, 8'h00);
    smp();
    chk("cw_we",    32'(bus.ram_we),    32'd1);
    chk("cw_a",     32'(bus.ram_a),     32'h020);
    chk("cw_din",   32'(bus.ram_d_in),  32'h3C);
    chk("cw_ack",   32'(bus.ext_ack),   32'd0);
    chk("cw_stall", 32'(bus.cpu_stall), 32'd0);
    tick();
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    set_ext(1'b0, 1'b0, 12'h000, 8'h00);
    smp(); tick();
    set_cpu(1'b1, 1'b0, 12'h020, 8'h00);
    q_cpu.push_back(8'h3C);
    smp(); tick();
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    smp(); tick();

    // simultaneous rd+wr behaves as a write; read data is the old contents
    set_cpu(1'b0, 1'b1, 12'h030, 8'h5A);
    smp(); tick();
    set_cpu(1'b1, 1'b1, 12'h030, 8'h77);
    q_cpu.push_back(8'h5A);
    smp();
    chk("rw_we",  32'(bus.ram_we),   32'd1);
    chk("rw_din", 32'(bus.ram_d_in), 32'h77);
    tick();
    set_cpu(1'b1, 1'b0, 12'h030, 8'h00);
    q_cpu.push_back(8'h77);
    smp(); tick();
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    smp(); tick();

    // starvation: CPU reads continuously, ext forced in on the 5th cycle
    set_cpu(1'b1, 1'b0, 12'h020, 8'h00);
    set_ext(1'b1, 1'b0, 12'h010, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      if (c == 5) q_ext.push_back(8'hA5);
      else        q_cpu.push_back(8'h3C);
      smp();
      chk("st_ack",   32'(bus.ext_ack),   32'(c == 5));
      chk("st_stall", 32'(bus.cpu_stall), 32'(c == 5));
      tick();
    end
    set_ext(1'b0, 1'b0, 12'h000, 8'h00);
    q_cpu.push_back(8'h3C);
    smp(); tick();

    // dropped request restarts the starvation count
    set_ext(1'b1, 1'b0, 12'h010, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      q_cpu.push_back(8'h3C);
      smp();
      chk("drop_ack", 32'(bus.ext_ack), 32'd0);
      tick();
    end
    set_ext(1'b0, 1'b0, 12'h000, 8'h00);
    q_cpu.push_back(8'h3C);
    smp(); tick();
    set_ext(1'b1, 1'b0, 12'h010, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) q_ext.push_back(8'hA5);
      else        q_cpu.push_back(8'h3C);
      smp();
      chk("re_ack",   32'(bus.ext_ack),   32'(c == 5));
      chk("re_stall", 32'(bus.cpu_stall), 32'(c == 5));
      tick();
    end
    set_ext(1'b0, 1'b0, 12'h000, 8'h00);
    q_cpu.push_back(8'h3C);
    smp(); tick();
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    smp(); tick();

    // reset in the cycle after an ext read ack suppresses the return
    set_ext(1'b1, 1'b0, 12'h010, 8'h00);
    smp();
    chk("rr_ack", 32'(bus.ext_ack), 32'd1);
    tick();
    rst = 1'b1;
    set_cpu(1'b0, 1'b1, 12'h040, 8'hEE);
    smp();
    chk("rr_rv",    32'(bus.ext_rvalid), 32'd0);
    chk("rr_dout",  32'(bus.ext_d_out),  32'd0);
    chk("rr_we",    32'(bus.ram_we),     32'd0);
    chk("rr_ack2",  32'(bus.ext_ack),    32'd0);
    chk("rr_ram_a", 32'(bus.ram_a),      32'h040);
    tick();
    rst = 1'b0;
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    set_ext(1'b0, 1'b0, 12'h000, 8'h00);
    smp();
    chk("rr_rv_after",   32'(bus.ext_rvalid), 32'd0);
    chk("rr_dout_after", 32'(bus.ext_d_out),  32'd0);
    tick();
    smp(); tick();

    chk("q_ext_empty", 32'(q_ext.size()), 32'd0);
    chk("q_cpu_empty", 32'(q_cpu.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
